// File: rtl/zebra_pkg.sv
// Shared types and defaults for the zebra-crossing pixel pipeline.
// Holds the run-tracking FSM states and default threshold parameters.
// Also used by zebra_crossing_detector so both blocks agree on defaults.
package zebra_pkg;

  typedef enum logic {
    RUN_BLACK = 1'b0,
    RUN_WHITE = 1'b1
  } run_state_t;

  localparam int DEF_IMG_WIDTH       = 320;
  localparam int DEF_IMG_HEIGHT      = 240;
  localparam int DEF_PIX_W           = 8;
  localparam int DEF_WHITE_THRESHOLD = 180;
  localparam int DEF_MIN_RUN         = 8;
  localparam int DEF_MAX_RUN         = 64;
  localparam int DEF_MIN_STRIPES     = 3;
  localparam int DEF_MIN_ROWS        = 20;

  // Counter width able to index 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/white_run_tracker.sv
// Tracks horizontal white runs along a row and flags each run as it closes.
// Latency: run_closed/run_qualifies are combinational in the accepting cycle.
// Backpressure: state only advances when accept is high; stalls freeze it.
module white_run_tracker
  import zebra_pkg::*;
#(
  parameter int MIN_RUN = DEF_MIN_RUN,
  parameter int MAX_RUN = DEF_MAX_RUN
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pix_white,
  input  logic accept,
  input  logic row_end,
  output logic run_closed,
  output logic run_qualifies
);

  // Run length saturates at MAX_RUN+1, which is enough to know "too long".
  localparam int LW = $clog2(MAX_RUN + 2);
  localparam logic [LW-1:0] LEN_ONE = LW'(1);
  localparam logic [LW-1:0] LEN_SAT = LW'(MAX_RUN + 1);
  localparam logic [LW-1:0] LEN_MIN = LW'(MIN_RUN);
  localparam logic [LW-1:0] LEN_MAX = LW'(MAX_RUN);

  run_state_t      state, state_nxt;
  logic [LW-1:0]   run_len, len_nxt, close_len;

  // Next-state and run-close decision for the pixel being accepted.
  always_comb begin
    state_nxt  = state;
    len_nxt    = run_len;
    close_len  = run_len;
    run_closed = 1'b0;
    if (accept) begin
      if (pix_white) begin
        if (state == RUN_BLACK) begin
          close_len = LEN_ONE;
        end else if (run_len == LEN_SAT) begin
          close_len = LEN_SAT;
        end else begin
          close_len = run_len + LEN_ONE;
        end
        // A white pixel on the row's last column closes the run it extends.
        if (row_end) begin
          run_closed = 1'b1;
          state_nxt  = RUN_BLACK;
          len_nxt    = '0;
        end else begin
          state_nxt  = RUN_WHITE;
          len_nxt    = close_len;
        end
      end else begin
        run_closed = (state == RUN_WHITE);
        state_nxt  = RUN_BLACK;
        len_nxt    = '0;
      end
    end
    run_qualifies = run_closed && (close_len >= LEN_MIN) && (close_len <= LEN_MAX);
  end

  // Run state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= RUN_BLACK;
      run_len <= '0;
    end else begin
      state   <= state_nxt;
      run_len <= len_nxt;
    end
  end

endmodule

// File: rtl/zebra_stripe_classifier.sv
// Pass-through pixel stage that classifies each frame as a zebra crossing.
// Latency: 1 cycle pixel pass-through; frame results 1 cycle after last pixel.
// Backpressure: x_ready = y_ready | ~y_valid; stalls freeze all run/row state.
module zebra_stripe_classifier
  import zebra_pkg::*;
#(
  parameter int              IMG_WIDTH       = DEF_IMG_WIDTH,
  parameter int              IMG_HEIGHT      = DEF_IMG_HEIGHT,
  parameter int              W               = DEF_PIX_W,
  parameter logic [W-1:0]    WHITE_THRESHOLD = W'(DEF_WHITE_THRESHOLD),
  parameter int              MIN_RUN         = DEF_MIN_RUN,
  parameter int              MAX_RUN         = DEF_MAX_RUN,
  parameter int              MIN_STRIPES     = DEF_MIN_STRIPES,
  parameter int              MIN_ROWS        = DEF_MIN_ROWS
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              x_valid,
  output logic                              x_ready,
  input  logic [W-1:0]                      x_data,
  output logic                              y_valid,
  input  logic                              y_ready,
  output logic [W-1:0]                      y_data,
  output logic [$clog2(IMG_HEIGHT+1)-1:0]   stripe_rows,
  output logic [7:0]                        max_runs,
  output logic                              zebra_detected,
  output logic                              detection_valid
);

  localparam int XW = cnt_width(IMG_WIDTH);
  localparam int YW = cnt_width(IMG_HEIGHT);
  localparam int RW = $clog2(IMG_HEIGHT + 1);
  localparam logic [XW-1:0] X_LAST = XW'(IMG_WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_HEIGHT - 1);

  logic [XW-1:0] x_pos;
  logic [YW-1:0] y_pos;
  logic [7:0]    row_runs, max_acc, eff_count, max_eff;
  logic [RW-1:0] rows_acc, rows_eff;
  logic          accept, row_end, frame_end, row_ok;
  logic          run_closed, run_qualifies;

  assign x_ready   = y_ready | ~y_valid;
  assign accept    = x_valid && x_ready;
  assign row_end   = (x_pos == X_LAST);
  assign frame_end = accept && row_end && (y_pos == Y_LAST);

  white_run_tracker #(
    .MIN_RUN (MIN_RUN),
    .MAX_RUN (MAX_RUN)
  ) u_tracker (
    .clk           (clk),
    .rst_n         (rst_n),
    .pix_white     (x_data >= WHITE_THRESHOLD),
    .accept        (accept),
    .row_end       (row_end),
    .run_closed    (run_closed),
    .run_qualifies (run_qualifies)
  );

  // Effective row/frame figures include a run closing on the current pixel.
  always_comb begin
    eff_count = row_runs;
    if (run_qualifies && (row_runs != 8'hFF)) begin
      eff_count = row_runs + 8'd1;
    end
    row_ok   = (int'(eff_count) >= MIN_STRIPES);
    rows_eff = row_ok ? rows_acc + RW'(1) : rows_acc;
    max_eff  = (eff_count > max_acc) ? eff_count : max_acc;
  end

  // One-deep pass-through register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_valid <= 1'b0;
      y_data  <= '0;
    end else if (accept) begin
      y_valid <= 1'b1;
      y_data  <= x_data;
    end else if (y_ready) begin
      y_valid <= 1'b0;
    end
  end

  // Raster position, advanced only by accepted pixels.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_pos <= '0;
      y_pos <= '0;
    end else if (accept) begin
      if (row_end) begin
        x_pos <= '0;
        y_pos <= (y_pos == Y_LAST) ? '0 : y_pos + YW'(1);
      end else begin
        x_pos <= x_pos + XW'(1);
      end
    end
  end

  // Per-row stripe count and per-frame accumulators; cleared at their boundaries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_runs <= '0;
      rows_acc <= '0;
      max_acc  <= '0;
    end else if (accept) begin
      if (row_end) begin
        row_runs <= '0;
        if (frame_end) begin
          rows_acc <= '0;
          max_acc  <= '0;
        end else begin
          rows_acc <= rows_eff;
          max_acc  <= max_eff;
        end
      end else begin
        row_runs <= eff_count;
      end
    end
  end

  // Frame results, loaded and announced on the edge after the last pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stripe_rows     <= '0;
      max_runs        <= '0;
      zebra_detected  <= 1'b0;
      detection_valid <= 1'b0;
    end else begin
      detection_valid <= frame_end;
      if (frame_end) begin
        stripe_rows    <= rows_eff;
        max_runs       <= max_eff;
        zebra_detected <= (int'(rows_eff) >= MIN_ROWS);
      end
    end
  end

endmodule

// File: tb/tb_zebra_stripe_classifier.sv
// Self-checking bench for zebra_stripe_classifier on a 16x4 frame.
// Pixel data and frame results are scoreboarded against an independent model.
// Random ready/valid gaps exercise the pass-through backpressure path.
module tb_zebra_stripe_classifier;

  localparam int IW = 16, IH = 4, NPIX = IW * IH;
  localparam int MINR = 2, MAXR = 4, MINS = 2, MINROWS = 2;
  localparam int RW = $clog2(IH + 1);
  localparam logic [7:0] WH = 8'd200, BL = 8'd0;

  typedef struct {
    int rows;
    int maxr;
    bit zeb;
  } res_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          x_valid = 1'b0;
  logic          y_ready = 1'b1;
  logic [7:0]    x_data = 8'd0;
  logic          x_ready, y_valid, zebra_detected, detection_valid;
  logic [7:0]    y_data, max_runs;
  logic [RW-1:0] stripe_rows;

  int         errors = 0;
  int         checks = 0;
  logic [7:0] frame [NPIX];
  logic [7:0] data_q [$];
  res_t       res_q [$];
  bit         rand_ready = 1'b0;
  bit         gaps = 1'b0;
  bit         dv_exp = 1'b0;
  int         hs_cnt = 0;

  zebra_stripe_classifier #(
    .IMG_WIDTH       (IW),
    .IMG_HEIGHT      (IH),
    .W               (8),
    .WHITE_THRESHOLD (8'd180),
    .MIN_RUN         (MINR),
    .MAX_RUN         (MAXR),
    .MIN_STRIPES     (MINS),
    .MIN_ROWS        (MINROWS)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .x_valid         (x_valid),
    .x_ready         (x_ready),
    .x_data          (x_data),
    .y_valid         (y_valid),
    .y_ready         (y_ready),
    .y_data          (y_data),
    .stripe_rows     (stripe_rows),
    .max_runs        (max_runs),
    .zebra_detected  (zebra_detected),
    .detection_valid (detection_valid)
  );

  always #5 clk = ~clk;

  // Downstream ready: always high, or a coin flip per cycle.
  always begin
    @(posedge clk);
    #1;
    y_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Reference: segment each row into white runs and count the in-range ones.
  function automatic res_t model_frame();
    res_t r;
    r.rows = 0;
    r.maxr = 0;
    for (int y = 0; y < IH; y++) begin
      int cnt = 0;
      int len = 0;
      for (int x = 0; x <= IW; x++) begin
        if (x < IW && frame[y*IW + x] >= 8'd180) begin
          len++;
        end else begin
          if (len >= MINR && len <= MAXR) cnt++;
          len = 0;
        end
      end
      if (cnt >= MINS) r.rows++;
      if (cnt > r.maxr) r.maxr = cnt;
    end
    r.zeb = (r.rows >= MINROWS);
    return r;
  endfunction

  function automatic void set_row(input int y, input string s);
    for (int x = 0; x < IW; x++) begin
      frame[y*IW + x] = (s[x] == "W") ? WH : BL;
    end
  endfunction

  function automatic void fill_all(input string s);
    for (int y = 0; y < IH; y++) set_row(y, s);
  endfunction

  // Monitor: pulse timing, result scoreboard, pass-through data order, ready rule.
  always @(negedge clk) begin
    if (!rst_n) begin
      dv_exp = 1'b0;
      hs_cnt = 0;
    end else begin
      checks++;
      if (detection_valid !== dv_exp) begin
        errors++;
        $display("FAIL dv_timing: got %b want %b (hs_cnt=%0d)", detection_valid, dv_exp, hs_cnt);
      end
      if (detection_valid === 1'b1) begin
        checks++;
        if (res_q.size() == 0) begin
          errors++;
          $display("FAIL dv_unexpected: pulse with no frame expected");
        end else begin
          res_t r;
          r = res_q.pop_front();
          if ({stripe_rows, max_runs, zebra_detected} !== {RW'(r.rows), 8'(r.maxr), r.zeb}) begin
            errors++;
            $display("FAIL frame_result: got rows=%0d max=%0d zeb=%b want rows=%0d max=%0d zeb=%b",
                     stripe_rows, max_runs, zebra_detected, r.rows, r.maxr, r.zeb);
          end
        end
      end
      checks++;
      if (x_ready !== (y_ready | ~y_valid)) begin
        errors++;
        $display("FAIL x_ready_rule: got %b with y_valid=%b y_ready=%b", x_ready, y_valid, y_ready);
      end
      if (y_valid === 1'b1 && y_ready === 1'b1) begin
        checks++;
        if (data_q.size() == 0) begin
          errors++;
          $display("FAIL y_extra: got %0d with nothing outstanding", y_data);
        end else begin
          logic [7:0] e;
          e = data_q.pop_front();
          if (y_data !== e) begin
            errors++;
            $display("FAIL y_data: got %0d want %0d", y_data, e);
          end
        end
      end
      dv_exp = 1'b0;
      if (x_valid === 1'b1 && x_ready === 1'b1) begin
        data_q.push_back(x_data);
        hs_cnt++;
        if (hs_cnt == NPIX) begin
          dv_exp = 1'b1;
          hs_cnt = 0;
        end
      end
    end
  end

  task automatic finish_now();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  endtask

  // Drive npix pixels of frame[]; leaves x_valid high for back-to-back use.
  task automatic send_frame(input int npix);
    if (npix == NPIX) res_q.push_back(model_frame());
    for (int i = 0; i < npix; i++) begin
      bit acc = 1'b0;
      int tmo = 0;
      x_data  = frame[i];
      x_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      while (!acc) begin
        @(negedge clk);
        acc = (x_valid && x_ready);
        @(posedge clk);
        #1;
        if (!acc) begin
          tmo++;
          if (tmo > 1000) begin
            errors++;
            checks++;
            $display("FAIL pixel_timeout: pixel %0d never accepted", i);
            finish_now();
          end
          x_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
        end
      end
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    x_valid = 1'b0;
    while ((res_q.size() != 0 || data_q.size() != 0) && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    @(negedge clk);
    checks++;
    if (res_q.size() != 0 || data_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: results pending=%0d data pending=%0d want 0 0",
               res_q.size(), data_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({y_valid, y_data, stripe_rows, max_runs, zebra_detected, detection_valid, x_ready} !==
        {1'b0, 8'd0, RW'(0), 8'd0, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset_state: y_valid=%b y_data=%0d rows=%0d max=%0d zeb=%b dv=%b x_ready=%b want zeros and x_ready=1",
               y_valid, y_data, stripe_rows, max_runs, zebra_detected, detection_valid, x_ready);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_all_black();
    fill_all("0000000000000000");
    send_frame(NPIX);
    wait_idle();
    checks++;
    if ({stripe_rows, max_runs, zebra_detected} !== {RW'(0), 8'd0, 1'b0}) begin
      errors++;
      $display("FAIL all_black: got rows=%0d max=%0d zeb=%b want 0 0 0", stripe_rows, max_runs, zebra_detected);
    end
  endtask

  task automatic test_four_stripes();
    fill_all("0WWW0WWW0WWW0WWW");
    send_frame(NPIX);
    wait_idle();
    checks++;
    if ({stripe_rows, max_runs, zebra_detected} !== {RW'(4), 8'd4, 1'b1}) begin
      errors++;
      $display("FAIL four_stripes: got rows=%0d max=%0d zeb=%b want 4 4 1", stripe_rows, max_runs, zebra_detected);
    end
  endtask

  function automatic void fill_row_end_case();
    set_row(0, "0WW0000000000WWW");
    set_row(1, "0WW0000000000WWW");
    set_row(2, "0000000000000000");
    set_row(3, "0000000000000000");
  endfunction

  task automatic test_row_end_close();
    fill_row_end_case();
    send_frame(NPIX);
    wait_idle();
    checks++;
    if ({stripe_rows, max_runs, zebra_detected} !== {RW'(2), 8'd2, 1'b1}) begin
      errors++;
      $display("FAIL row_end_close: got rows=%0d max=%0d zeb=%b want 2 2 1", stripe_rows, max_runs, zebra_detected);
    end
  endtask

  task automatic test_no_qualify();
    fill_all("W0W0W0W0W0W0W0W0");
    set_row(0, "WWWWWWWWWWWWWWWW");
    send_frame(NPIX);
    wait_idle();
    checks++;
    if ({stripe_rows, max_runs, zebra_detected} !== {RW'(0), 8'd0, 1'b0}) begin
      errors++;
      $display("FAIL no_qualify: got rows=%0d max=%0d zeb=%b want 0 0 0", stripe_rows, max_runs, zebra_detected);
    end
  endtask

  task automatic test_backpressure();
    fill_all("0WWW0WWW0WWW0WWW");
    for (int i = 0; i < NPIX; i++) frame[i] = frame[i] | 8'(i);
    rand_ready = 1'b1;
    gaps = 1'b1;
    send_frame(NPIX);
    x_valid = 1'b0;
    rand_ready = 1'b0;
    gaps = 1'b0;
    wait_idle();
    checks++;
    if ({stripe_rows, max_runs, zebra_detected} !== {RW'(4), 8'd4, 1'b1}) begin
      errors++;
      $display("FAIL backpressure: got rows=%0d max=%0d zeb=%b want 4 4 1", stripe_rows, max_runs, zebra_detected);
    end
  endtask

  task automatic test_back_to_back();
    fill_row_end_case();
    send_frame(NPIX);
    fill_all("0WWW0WWW0WWW0WWW");
    send_frame(NPIX);
    wait_idle();
    checks++;
    if ({stripe_rows, max_runs, zebra_detected} !== {RW'(4), 8'd4, 1'b1}) begin
      errors++;
      $display("FAIL back_to_back: got rows=%0d max=%0d zeb=%b want 4 4 1", stripe_rows, max_runs, zebra_detected);
    end
  endtask

  task automatic test_mid_reset();
    fill_all("0WWW0WWW0WWW0WWW");
    send_frame(30);
    x_valid = 1'b0;
    rst_n = 1'b0;
    data_q.delete();
    res_q.delete();
    @(negedge clk);
    checks++;
    if ({y_valid, y_data, stripe_rows, max_runs, zebra_detected, detection_valid} !==
        {1'b0, 8'd0, RW'(0), 8'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL mid_reset_outputs: y_valid=%b y_data=%0d rows=%0d max=%0d zeb=%b dv=%b want all 0",
               y_valid, y_data, stripe_rows, max_runs, zebra_detected, detection_valid);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    fill_row_end_case();
    send_frame(NPIX);
    wait_idle();
    checks++;
    if ({stripe_rows, max_runs, zebra_detected} !== {RW'(2), 8'd2, 1'b1}) begin
      errors++;
      $display("FAIL mid_reset_frame: got rows=%0d max=%0d zeb=%b want 2 2 1", stripe_rows, max_runs, zebra_detected);
    end
  endtask

  initial begin
    test_reset();
    test_all_black();
    test_four_stripes();
    test_row_end_close();
    test_no_qualify();
    test_backpressure();
    test_back_to_back();
    test_mid_reset();
    finish_now();
  end

endmodule

// File: doc/zebra_stripe_classifier.md
# zebra_stripe_classifier

Frame-level zebra-crossing classifier that sits directly downstream of `zebra_crossing_detector` in the pixel pipeline. It consumes the same 8-bit grayscale valid/ready stream and passes it on unchanged through a one-deep register. It binarises each pixel, measures horizontal white runs per row, and counts rows that contain enough stripe-width runs. At each frame end it publishes a registered crossing decision with a one-cycle `detection_valid` pulse, replacing the detector's stubbed decision path.

## Interface
- `IMG_WIDTH`, 320: pixels per row.
- `IMG_HEIGHT`, 240: rows per frame.
- `W`, 8: pixel width.
- `WHITE_THRESHOLD`, 8'd180: pixel is white when `x_data >= WHITE_THRESHOLD`.
- `MIN_RUN`, 8: minimum white-run length that counts as a stripe.
- `MAX_RUN`, 64: maximum white-run length that counts as a stripe.
- `MIN_STRIPES`, 3: stripe runs a row needs to qualify.
- `MIN_ROWS`, 20: qualifying rows a frame needs for a detection.
- `clk` in 1: single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `x_valid` in 1: input pixel valid.
- `x_ready` out 1: input ready.
- `x_data` in W: grayscale pixel, raster order.
- `y_valid` out 1: pass-through valid.
- `y_ready` in 1: downstream ready.
- `y_data` out W: pass-through pixel.
- `stripe_rows` out `$clog2(IMG_HEIGHT+1)`: qualifying rows in the last completed frame.
- `max_runs` out 8: largest per-row stripe count in the last completed frame.
- `zebra_detected` out 1: `stripe_rows >= MIN_ROWS` for the last completed frame.
- `detection_valid` out 1: one-cycle pulse when the frame results update.

## Operation
- Handshake: a pixel is accepted when `x_valid && x_ready`; `x_ready = y_ready | ~y_valid`.
- Pass-through register:
  - On handshake: `y_valid <= 1`, `y_data <= x_data`.
  - Else if `y_ready`: `y_valid <= 0`.
- Position: `x_pos` and `y_pos` advance only on handshake. `x_pos` wraps at `IMG_WIDTH-1`; `y_pos` wraps at `IMG_HEIGHT-1`. Frame end is the handshake at (`IMG_WIDTH-1`, `IMG_HEIGHT-1`).
- Run FSM, advanced only on handshake:
  - BLACK, white pixel → IN_RUN, `run_len = 1`.
  - IN_RUN, white pixel → stay in IN_RUN, `run_len` saturates at `MAX_RUN+1`.
  - IN_RUN, black pixel → close the run, go to BLACK.
  - Last pixel of a row → close any open run (including one that starts on that pixel), go to BLACK.
- A closed run qualifies iff `MIN_RUN <= run_len <= MAX_RUN`. A qualifying run increments `row_runs`, which saturates at 255.
- Row end, evaluated with the effective count that includes a run closing on this pixel:
  - Row qualifies iff effective count `>= MIN_STRIPES`; a qualifying row increments `rows_acc`.
  - `max_acc = max(max_acc, effective count)`.
  - `row_runs` clears.
- Frame end, using accumulators that include the final row:
  - `stripe_rows`, `max_runs` and `zebra_detected` load from the accumulators.
  - `detection_valid` pulses.
  - `rows_acc` and `max_acc` clear in the same cycle.
- Outputs hold their values between frames.
- Reset: every output and internal register goes to 0 and the FSM to BLACK. A mid-frame reset discards the partial frame; the next accepted pixel is position (0,0).

## Timing
- Pass-through latency: 1 cycle.
- Throughput: 1 pixel/cycle while `y_ready` stays high.
- `detection_valid`: high exactly one cycle, on the clock edge after the final pixel's handshake. Result outputs change on that same edge.
- Stalled cycles (no handshake) change no run, row or position state.
- A frame end followed immediately by the next frame's first pixel: the new pixel starts from cleared accumulators, with no lost or double-counted pixel.

## Structure
- Package `zebra_pkg`: run-FSM state enum (`RUN_BLACK`, `RUN_WHITE`) and shared threshold/default constants, also used by `zebra_crossing_detector`.
- Sub-module `white_run_tracker`:
  - Inputs: pixel-white, accept, row-end.
  - Outputs: `run_closed` and `run_qualifies`.
- Top level holds the position counters, row/frame accumulators and pass-through register.

## Test plan
Bench parameters: `IMG_WIDTH=16`, `IMG_HEIGHT=4`, `MIN_RUN=2`, `MAX_RUN=4`, `MIN_STRIPES=2`, `MIN_ROWS=2`. White = 200, black = 0.
- All-black frame → `detection_valid` one cycle after the 64th handshake; `stripe_rows=0`, `max_runs=0`, `zebra_detected=0`.
- Every row `0WWW0WWW0WWW0WWW` → 4 runs/row; `stripe_rows=4`, `max_runs=4`, `zebra_detected=1`.
- Rows `0WW0000000000WWW` (final run closed by row end) in rows 0–1, all-black rows 2–3 → `stripe_rows=2`, `max_runs=2`, `zebra_detected=1`.
- All-white row plus single-W runs, e.g. rows `W0W0W0W0W0W0W0W0` → no run qualifies (length 16 > 4, length 1 < 2); `stripe_rows=0`, `zebra_detected=0`.
- Pattern from scenario 2 with random `y_ready` (≈50%) and random `x_valid` gaps:
  - `x_ready=0` whenever `y_valid && !y_ready`.
  - `y_data` order matches input.
  - Results identical to scenario 2.
- Drop `rst_n` after 30 pixels of a scenario-2 frame, then send a full scenario-3 frame:
  - During reset, all outputs are 0.
  - The frame completes after exactly 64 further handshakes, with `stripe_rows=2`.
